// File: rtl/frame_max_tracker_pkg.sv
// frame_max_pkg: shared state encoding and default widths for the frame max tracker
package frame_max_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_IDX_W = 8;

endpackage

// File: rtl/frame_max_tracker_cmp.sv
// max_cmp8: unsigned greater-than of a new sample against the stored maximum
module majorComparator #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         gt_o
);

    assign gt_o = a_i > b_i;

endmodule

module max_cmp8 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [WIDTH-1:0] max_val_i,
    output logic             gt_o
);

    majorComparator #(.W(WIDTH)) u_cmp (
        .a_i (in_data_i),
        .b_i (max_val_i),
        .gt_o(gt_o)
    );

endmodule

// File: rtl/frame_max_tracker.sv
// frame_max_tracker: per-frame running maximum with first-occurrence index and saturating count
module frame_max_tracker
    import frame_max_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] max_val,
    output logic [IDX_W-1:0] max_idx,
    output logic [IDX_W-1:0] count,
    output logic             ovf
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             first_q, first_d;
    logic             gt, accept, clear, take, sat;

    max_cmp8 #(.WIDTH(WIDTH)) u_cmp (
        .in_data_i(in_data),
        .max_val_i(max_q),
        .gt_o     (gt)
    );

    // first_q forces the opening sample in even when it does not beat the cleared maximum
    always_comb begin
        accept  = state_q == RUN && in_valid;
        clear   = start && (state_q == IDLE || (state_q == DONE && out_ready));
        take    = accept && (first_q || gt);
        sat     = &cnt_q;
        state_d = state_q == IDLE ? (start ? RUN : IDLE)
                : state_q == RUN  ? (accept && in_last ? DONE : RUN)
                : out_ready       ? (start ? RUN : IDLE) : DONE;
        max_d   = clear ? '0 : take ? in_data : max_q;
        idx_d   = clear ? '0 : take ? cnt_q : idx_q;
        cnt_d   = clear ? '0 : (accept && !sat) ? cnt_q + IDX_W'(1) : cnt_q;
        ovf_d   = clear ? 1'b0 : ovf_q | (accept & sat);
        first_d = clear | (first_q & ~accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            max_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            first_q <= first_d;
        end
    end

    assign in_ready  = state_q == RUN;
    assign out_valid = state_q == DONE;
    assign max_val   = max_q;
    assign max_idx   = idx_q;
    assign count     = cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_frame_max_tracker.sv
// tb_frame_max_tracker: randomized frames against a queue-based max model, two counter widths
module tb_frame_max_tracker;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, in_last, out_ready;
    logic [7:0] in_data;
    logic       rdy8, vld8, ovf8, rdy2, vld2, ovf2;
    logic [7:0] mv8, mi8, ct8, mv2;
    logic [1:0] mi2, ct2;
    int         vectors = 0;
    int         errors = 0;
    logic [7:0] frm[$];

    logic [7:0] dir_d [5][5] = '{
        '{8'h05, 8'h40, 8'h03, 8'h00, 8'h00},
        '{8'h10, 8'h22, 8'h22, 8'h10, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h7B, 8'hCA, 8'hFB, 8'h35, 8'h00},
        '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}};
    int dir_n [5] = '{3, 4, 1, 4, 5};

    wire [26:0] o8 = {rdy8, vld8, mv8, mi8, ct8, ovf8};
    wire [14:0] o2 = {rdy2, vld2, mv2, mi2, ct2, ovf2};

    always #5 clk = ~clk;

    frame_max_tracker #(.WIDTH(8), .IDX_W(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy8), .out_valid(vld8), .out_ready(out_ready),
        .max_val(mv8), .max_idx(mi8), .count(ct8), .ovf(ovf8));

    frame_max_tracker #(.WIDTH(8), .IDX_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy2), .out_valid(vld2), .out_ready(out_ready),
        .max_val(mv2), .max_idx(mi2), .count(ct2), .ovf(ovf2));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if (o8 !== 27'd0) begin errors++; $display("FAIL reset_w8 got %h want 0", o8); end
        vectors++;
        if (o2 !== 15'd0) begin errors++; $display("FAIL reset_w2 got %h want 0", o2); end
        step();
        vectors++;
        if ({o8, o2} !== 42'd0) begin errors++; $display("FAIL idle_hold got %h/%h want 0", o8, o2); end
    endtask

    task automatic run_frame(input bit gaps);
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if ({rdy8, vld8, rdy2, vld2} !== 4'b1010) begin
            errors++; $display("FAIL run_entry got %b want 1010", {rdy8, vld8, rdy2, vld2});
        end
        foreach (frm[i]) begin
            if (gaps) repeat ($urandom_range(1, 2)) begin
                in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom); start = 1'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_data  = frm[i];
            in_last  = (i == frm.size() - 1);
            start    = 1'($urandom);
            step();
            if (i != frm.size() - 1) begin
                vectors++;
                if ({rdy8, vld8, rdy2, vld2} !== 4'b1010) begin
                    errors++; $display("FAIL in_frame got %b want 1010 at %0d", {rdy8, vld8, rdy2, vld2}, i);
                end
            end
        end
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        vectors++;
        if ({rdy8, vld8, rdy2, vld2} !== 4'b0101) begin
            errors++; $display("FAIL latency got %b want 0101", {rdy8, vld8, rdy2, vld2});
        end
    endtask

    task automatic test_frames;
        int n, fi;
        logic [7:0] mx;
        bit gaps;
        for (int f = 0; f < 30; f++) begin
            frm.delete();
            if (f < 5) begin
                for (int i = 0; i < dir_n[f]; i++) frm.push_back(dir_d[f][i]);
                gaps = (f == 3);
            end else begin
                repeat ($urandom_range(1, 8))
                    frm.push_back(f[0] ? 8'($urandom) : 8'($urandom_range(0, 3) << 6));
                gaps = 1'($urandom);
            end
            run_frame(gaps);
            n = frm.size();
            mx = 8'h00;
            foreach (frm[i]) if (frm[i] > mx) mx = frm[i];
            fi = 0;
            while (frm[fi] != mx) fi++;
            vectors++;
            if (o8 !== {1'b0, 1'b1, mx, 8'(fi), 8'(n), 1'b0}) begin
                errors++; $display("FAIL frame%0d_w8 got %h want %h", f, o8, {1'b0, 1'b1, mx, 8'(fi), 8'(n), 1'b0});
            end
            vectors++;
            if (o2 !== {1'b0, 1'b1, mx, 2'(fi > 3 ? 3 : fi), 2'(n > 3 ? 3 : n), n > 3}) begin
                errors++;
                $display("FAIL frame%0d_w2 got %h want %h", f, o2,
                         {1'b0, 1'b1, mx, 2'(fi > 3 ? 3 : fi), 2'(n > 3 ? 3 : n), n > 3});
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            vectors++;
            if ({rdy8, vld8, rdy2, vld2} !== 4'b0000) begin
                errors++; $display("FAIL release%0d got %b want 0000", f, {rdy8, vld8, rdy2, vld2});
            end
        end
    endtask

    task automatic test_back_to_back;
        frm.delete();
        frm.push_back(8'h11); frm.push_back(8'h99); frm.push_back(8'h42);
        run_frame(1'b0);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; start = 1'b1; in_data = 8'($urandom); in_last = 1'($urandom);
            step();
            vectors++;
            if ({o8, o2} !== {1'b0, 1'b1, 8'h99, 8'd1, 8'd3, 1'b0, 1'b0, 1'b1, 8'h99, 2'd1, 2'd3, 1'b0}) begin
                errors++; $display("FAIL hold%0d got %h/%h want 099 idx1 cnt3", c, o8, o2);
            end
        end
        out_ready = 1'b1; start = 1'b1;
        step();
        out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
        vectors++;
        if ({o8, o2} !== {1'b1, 26'd0, 1'b1, 14'd0}) begin
            errors++; $display("FAIL b2b_restart got %h/%h want run cleared", o8, o2);
        end
        in_valid = 1'b1; in_data = 8'h07; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        vectors++;
        if ({o8, o2} !== {1'b0, 1'b1, 8'h07, 8'd0, 8'd1, 1'b0, 1'b0, 1'b1, 8'h07, 2'd0, 2'd1, 1'b0}) begin
            errors++; $display("FAIL b2b_frame got %h/%h want 07 idx0 cnt1", o8, o2);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
        step();
        in_data = 8'h55;
        step();
        rst = 1'b1; in_last = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        vectors++;
        if ({o8, o2} !== 42'd0) begin errors++; $display("FAIL rst_run got %h/%h want 0", o8, o2); end
        in_valid = 1'b1; in_data = 8'hF0;
        step();
        in_valid = 1'b0;
        vectors++;
        if ({o8, o2} !== 42'd0) begin errors++; $display("FAIL rst_idle got %h/%h want 0", o8, o2); end
        frm.delete();
        frm.push_back(8'h33); frm.push_back(8'h44);
        run_frame(1'b0);
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b0;
        vectors++;
        if ({o8, o2} !== 42'd0) begin errors++; $display("FAIL rst_done got %h/%h want 0", o8, o2); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        test_reset();
        test_frames();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/frame_max_tracker.md
Name: frame_max_tracker

Overview:
- Streaming consumer of the 8-bit unsigned greater-than comparison.
- Accepts a frame of byte samples one per cycle and tracks the running maximum and the index of its first occurrence.
- At end of frame, presents max value, index and sample count on a held result interface.
- Sits downstream of the comparator: every sample is compared against the stored maximum by one comparator instance.

Parameters:
- WIDTH, 8, sample width in bits; unsigned compare.
- IDX_W, 8, width of index and count registers.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin new frame (sampled in IDLE, or in DONE with out_ready)
- in_valid  in  1  sample present
- in_data  in  WIDTH  sample value
- in_last  in  1  final sample of frame, qualified by in_valid
- in_ready  out  1  block accepts a sample this cycle
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- max_val  out  WIDTH  frame maximum
- max_idx  out  IDX_W  zero-based index of first occurrence of maximum
- count  out  IDX_W  samples accepted in frame (saturating)
- ovf  out  1  sticky: frame exceeded 2^IDX_W-1 samples

Behaviour:
- Single clock clk. rst is synchronous and active-high.
- Reset: state IDLE; in_ready=0, out_valid=0, max_val=0, max_idx=0, count=0, ovf=0.
- Reset mid-frame or mid-DONE aborts immediately. No partial result is emitted.
- State IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> RUN next cycle; clears max_val, max_idx, count, ovf and sets internal first flag.
- State RUN:
  - in_ready=1. A sample is accepted when in_valid=1.
  - Update rule on accept: if first flag, or in_data > max_val (unsigned, via comparator), then max_val<=in_data and max_idx<=count; first flag clears.
  - Ties (equal value) keep the earlier index. The first sample is always taken, including 0x00.
  - count increments per accepted sample. At 2^IDX_W-1 it saturates; a further accepted sample sets ovf. max_idx for such samples uses the saturated count.
  - Accepted sample with in_last=1 -> DONE next cycle.
  - start in RUN is ignored. in_valid=0 cycles are bubbles with no state change.
- State DONE:
  - out_valid=1, in_ready=0. max_val, max_idx, count and ovf are held stable.
  - out_ready=1 -> IDLE, or RUN with registers cleared if start=1 in the same cycle (back-to-back frames).
  - in_valid is ignored.
- Latency: out_valid rises the cycle after the in_last beat is accepted.
- Outputs are registered, with no combinational path from in_data to max_val.
- in_ready and out_valid are decoded from state only, with no dependence on in_valid or out_ready.

Decomposition:
- Package frame_max_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Default WIDTH/IDX_W constants.
- Sub-module max_cmp8:
  - Wraps majorComparator (8-bit unsigned A>B).
  - Exposes a single gt bit, with A=in_data and B=max_val.
- Top level holds the FSM, registers and counter.

Test Plan:
- start, then frame 0x05,0x40,0x03 (last on 0x03) -> out_valid one cycle after last; max_val=0x40, max_idx=1, count=3, ovf=0.
- Frame 0x10,0x22,0x22,0x10 -> max_val=0x22, max_idx=1 (tie keeps earlier); count=4.
- Single-sample frame 0x00 with in_last -> max_val=0x00, max_idx=0, count=1.
- Unsigned check, frame 0x7B,0xCA,0xFB,0x35 with in_valid gaps between samples -> max_val=0xFB, max_idx=2, count=4.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 and start=1 -> outputs stable, in_ready=0. Then out_ready=1 with start=1 -> RUN next cycle, count=0.
- IDX_W=2: feed 5 samples -> count=3, ovf=1. Separately, assert rst mid-frame -> next cycle IDLE, all outputs 0, no out_valid.
